aibcr3_avmm_clkdiv_gate: RTL and testbench

Programmable clock divider and request/idle-based clock gate that generates the strobe source for the AVMM skew-matched clock distribution tree. It sits directly upstream of the tree: its `clkdiv_out` drives the tree's `clkin`. It guarantees glitch-free start, stop and ratio change: no high phase shorter than the programmed half-period, and no runt pulses. All logic runs on one clock; all outputs are registered.

---
 rtl/aibcr3_avmm_clkdiv_gate_if.sv | 25 ++
 rtl/aibcr3_avmm_clkdiv_gate.sv | 129 ++++++++++++
 tb/tb_aibcr3_avmm_clkdiv_gate.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aibcr3_avmm_clkdiv_gate_if.sv
// Control/status bundle of the AVMM strobe-source divider and gate.
// clk_req/clk_ack form a level handshake: clk_req high asks for the divided clock, and clk_ack is high while it runs.
interface aibcr3_avmm_clkdiv_gate_if #(
    parameter int DIV_W  = 4,
    parameter int IDLE_W = 8
);
    logic [DIV_W-1:0]  div_ratio;
    logic              clk_req;
    logic              activity;
    logic [IDLE_W-1:0] idle_limit;
    logic              clkdiv_out;
    logic              clk_ack;
    logic              auto_gated;
    logic [1:0]        state;       // FSM state for observation: 0=OFF 1=RUN 2=DRAIN

    modport master (
        output div_ratio, clk_req, activity, idle_limit,
        input  clkdiv_out, clk_ack, auto_gated, state
    );

    modport slave (
        input  div_ratio, clk_req, activity, idle_limit,
        output clkdiv_out, clk_ack, auto_gated, state
    );
endinterface

// File: rtl/aibcr3_avmm_clkdiv_gate.sv
// Glitch-free programmable divider plus request/idle clock gate feeding the AVMM clock tree.
// Stopping never truncates a high phase, and a new ratio is picked up only at a falling toggle.
module aibcr3_avmm_clkdiv_gate #(
    parameter int DIV_W  = 4,
    parameter int IDLE_W = 8
) (
    input  logic                         cfg_avmm_clk,
    input  logic                         cfg_avmm_rst_n,
    aibcr3_avmm_clkdiv_gate_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_lat;
    logic              clkdiv_q;
    logic              ack_q;
    logic [IDLE_W-1:0] idle_cnt;
    logic              auto_gated_q;

    logic              stop;
    logic              tgl;
    logic              rise;
    logic              fall;
    logic [DIV_W-1:0]  cnt_nxt;
    logic              idle_hit;

    assign stop = ~bus.clk_req | auto_gated_q;
    assign tgl  = (cnt == div_lat);

    always_comb begin
        rise    = 1'b0;
        fall    = 1'b0;
        cnt_nxt = cnt + DIV_W'(1);
        if (tgl) begin
            rise    = ~clkdiv_q;
            fall    = clkdiv_q;
            cnt_nxt = '0;
        end
    end

    // Divider and gate FSM; clkdiv_out is driven straight from clkdiv_q so the tree never sees logic glitches.
    always_ff @(posedge cfg_avmm_clk) begin
        if (!cfg_avmm_rst_n) begin
            state    <= ST_OFF;
            cnt      <= '0;
            div_lat  <= '0;
            clkdiv_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    clkdiv_q <= 1'b0;
                    cnt      <= '0;
                    if (bus.clk_req && !auto_gated_q) begin
                        state   <= ST_RUN;
                        div_lat <= bus.div_ratio;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (stop && !clkdiv_q) begin
                        // Low phase: stop right here and cancel any pending rise.
                        state <= ST_OFF;
                        cnt   <= '0;
                        ack_q <= 1'b0;
                    end else begin
                        cnt      <= cnt_nxt;
                        clkdiv_q <= clkdiv_q ^ tgl;
                        if (fall) begin
                            div_lat <= bus.div_ratio;
                        end
                        if (rise) begin
                            ack_q <= 1'b1;
                        end
                        if (fall && stop) begin
                            state <= ST_OFF;
                            cnt   <= '0;
                            ack_q <= 1'b0;
                        end else if (stop) begin
                            state <= ST_DRAIN;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state    <= ST_OFF;
                    cnt      <= '0;
                    clkdiv_q <= 1'b0;
                    ack_q    <= 1'b0;
                end
            endcase
        end
    end

    assign idle_hit = (state != ST_OFF) && (bus.idle_limit != '0) &&
                      (idle_cnt == bus.idle_limit - IDLE_W'(1));

    // Idle timeout: clearing wins over setting so a request drop or traffic always re-arms the gate.
    always_ff @(posedge cfg_avmm_clk) begin
        if (!cfg_avmm_rst_n) begin
            idle_cnt     <= '0;
            auto_gated_q <= 1'b0;
        end else begin
            if (state == ST_OFF || bus.activity || bus.idle_limit == '0) begin
                idle_cnt <= '0;
            end else if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (bus.activity || !bus.clk_req) begin
                auto_gated_q <= 1'b0;
            end else if (idle_hit) begin
                auto_gated_q <= 1'b1;
            end
        end
    end

    assign bus.clkdiv_out = clkdiv_q;
    assign bus.clk_ack    = ack_q;
    assign bus.auto_gated = auto_gated_q;
    assign bus.state      = state;

endmodule

// File: tb/tb_aibcr3_avmm_clkdiv_gate.sv
// Bench for aibcr3_avmm_clkdiv_gate: directed timing steps followed by random traffic,
// with every cycle compared against a phase-countdown model of the divider and gate.
module tb_aibcr3_avmm_clkdiv_gate;
  localparam int DIV_W  = 4;
  localparam int IDLE_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  // model: running flag, output level, ack, sticky gate, cycles left in phase, phase length, idle run length
  bit m_run, m_lvl, m_ack, m_ag;
  int m_left, m_len, m_idle;

  aibcr3_avmm_clkdiv_gate_if #(.DIV_W(DIV_W), .IDLE_W(IDLE_W)) bus ();

  aibcr3_avmm_clkdiv_gate #(.DIV_W(DIV_W), .IDLE_W(IDLE_W)) dut (
    .cfg_avmm_clk  (clk),
    .cfg_avmm_rst_n(rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit stop;
    bit ag_n;
    int idle_n;
    if (!rst_n) begin
      m_run = 0; m_lvl = 0; m_ack = 0; m_ag = 0; m_idle = 0; m_left = 0; m_len = 0;
    end else begin
      stop = !bus.clk_req || m_ag;
      ag_n = m_ag;
      if (bus.activity || !bus.clk_req) ag_n = 0;
      else if (m_run && bus.idle_limit != 0 && m_idle == int'(bus.idle_limit) - 1) ag_n = 1;
      idle_n = (!m_run || bus.activity || bus.idle_limit == 0) ? 0 : m_idle + 1;
      if (!m_run) begin
        if (bus.clk_req && !m_ag) begin
          m_run  = 1;
          m_len  = int'(bus.div_ratio) + 1;
          m_left = m_len;
        end
      end else if (stop && !m_lvl) begin
        m_run = 0;
        m_ack = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_lvl = !m_lvl;
          if (m_lvl) begin
            m_ack = 1;
          end else begin
            m_len = int'(bus.div_ratio) + 1;
            if (stop) begin
              m_run = 0;
              m_ack = 0;
            end
          end
          m_left = m_len;
        end
      end
      m_ag   = ag_n;
      m_idle = idle_n;
    end
    exp_q.push_back({m_lvl, m_ack, m_ag});
  endtask

  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    chk_bit("clkdiv_out", bus.clkdiv_out, e[2]);
    chk_bit("clk_ack", bus.clk_ack, e[1]);
    chk_bit("auto_gated", bus.auto_gated, e[0]);
  endtask

  // edges until clkdiv_out leaves lvl (bounded)
  task automatic measure(input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.clkdiv_out === lvl && n < 64);
  endtask

  task automatic chk_zero(input string tag);
    chk_bit({tag, "_out"}, bus.clkdiv_out, 1'b0);
    chk_bit({tag, "_ack"}, bus.clk_ack, 1'b0);
    chk_bit({tag, "_ag"}, bus.auto_gated, 1'b0);
  endtask

  initial begin
    int n;
    bus.div_ratio  = '0;
    bus.clk_req    = 1'b0;
    bus.activity   = 1'b0;
    bus.idle_limit = '0;

    // reset
    rst_n = 1'b0;
    repeat (3) step();
    chk_zero("reset");

    // start at ratio 2: first rise 3 cycles after the request edge, then 3/3
    rst_n = 1'b1;
    bus.div_ratio = 4'd2;
    bus.clk_req = 1'b1;
    step();
    measure(1'b0, n); chk_int("start_lat_r2", n, 3);
    chk_bit("start_ack", bus.clk_ack, 1'b1);
    measure(1'b1, n); chk_int("high_r2", n, 3);
    measure(1'b0, n); chk_int("low_r2", n, 3);

    // ratio 3, then drop to 0 one cycle into a high phase
    bus.div_ratio = 4'd3;
    measure(1'b1, n); chk_int("high_old_r2", n, 3);
    measure(1'b0, n); chk_int("low_r3", n, 4);
    step();
    bus.div_ratio = 4'd0;
    measure(1'b1, n); chk_int("high_r3_rest", n, 3);
    measure(1'b0, n); chk_int("low_r0", n, 1);
    measure(1'b1, n); chk_int("high_r0", n, 1);

    // ratio 4, drop request one cycle into the high phase: full 5-cycle high, then OFF
    bus.div_ratio = 4'd4;
    if (bus.clkdiv_out === 1'b1) measure(1'b1, n);
    else begin
      measure(1'b0, n);
      measure(1'b1, n);
    end
    measure(1'b0, n); chk_int("low_r4", n, 5);
    step();
    bus.clk_req = 1'b0;
    measure(1'b1, n); chk_int("drain_high_rest", n, 4);
    chk_bit("drain_ack", bus.clk_ack, 1'b0);

    // drop request in a low phase: OFF at that edge with no rise
    bus.clk_req = 1'b1;
    step();
    repeat (2) step();
    bus.clk_req = 1'b0;
    step();
    chk_bit("lowstop_out", bus.clkdiv_out, 1'b0);
    chk_bit("lowstop_ack", bus.clk_ack, 1'b0);
    repeat (12) step();

    // idle timeout with limit 5
    bus.div_ratio = 4'd1;
    bus.idle_limit = 8'd5;
    bus.clk_req = 1'b1;
    step();
    repeat (4) step();
    chk_bit("ag_before", bus.auto_gated, 1'b0);
    step();
    chk_bit("ag_set", bus.auto_gated, 1'b1);
    n = 0;
    while (bus.clk_ack === 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk_bit("ag_stop_out", bus.clkdiv_out, 1'b0);
    chk_bit("ag_stop_ack", bus.clk_ack, 1'b0);
    repeat (5) step();
    bus.activity = 1'b1;
    step();
    chk_bit("ag_clear", bus.auto_gated, 1'b0);
    bus.activity = 1'b0;
    step();
    measure(1'b0, n); chk_int("ag_restart_lat", n, 2);

    // limit 0: never gates
    bus.idle_limit = 8'd0;
    repeat (300) step();
    chk_bit("nolimit_ag", bus.auto_gated, 1'b0);
    chk_bit("nolimit_ack", bus.clk_ack, 1'b1);

    // reset mid-high phase, then restart timing
    if (bus.clkdiv_out !== 1'b1) measure(1'b0, n);
    rst_n = 1'b0;
    step();
    chk_zero("rst_run");
    bus.div_ratio = 4'd2;
    rst_n = 1'b1;
    step();
    measure(1'b0, n); chk_int("rst_run_restart", n, 3);

    // reset during DRAIN
    bus.div_ratio = 4'd4;
    measure(1'b1, n);
    measure(1'b0, n);
    step();
    bus.clk_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk_zero("rst_drain");

    // reset in OFF
    rst_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk_zero("rst_off");
    rst_n = 1'b1;
    bus.clk_req = 1'b1;
    bus.div_ratio = 4'd2;
    step();
    measure(1'b0, n); chk_int("rst_off_restart", n, 3);

    // random traffic against the model
    repeat (3000) begin
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 39) == 0) bus.clk_req = ~bus.clk_req;
      bus.activity = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 29) == 0) bus.div_ratio = DIV_W'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0)
        bus.idle_limit = ($urandom_range(0, 3) == 0) ? '0 : IDLE_W'($urandom_range(1, 40));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
